// File: rtl/spi_slave_fsm.sv
// SPI slave front end: assembles 10-bit {cmd, payload} words from MOSI and
// shifts RAM read data out on MISO after a read-data command.
module spi_slave_fsm #(
  parameter int WORD_W = 10,
  parameter int TX_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [TX_W-1:0]   tx_data,
  input  logic              tx_valid
);

  localparam int BC_W = $clog2(WORD_W);
  localparam int TC_W = $clog2(TX_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 2);
  localparam logic [TC_W-1:0] TX_LAST  = TC_W'(TX_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK_CMD,
    S_WRITE,
    S_READ_ADD,
    S_READ_DATA
  } state_t;

  state_t            r_state;
  logic [WORD_W-2:0] r_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic              r_word_done;
  logic              r_rd_addr_done;
  logic              r_tx_busy;
  logic              r_tx_done;
  logic [TX_W-1:0]   r_tx_shift;
  logic [TC_W-1:0]   r_tx_cnt;
  logic              r_miso;
  logic              r_rx_valid;
  logic [WORD_W-1:0] r_rx_data;

  logic w_abort;
  logic w_last_bit;

  assign w_abort    = (r_state != S_IDLE) && SS_n;
  assign w_last_bit = (r_bit_cnt == LAST_BIT);

  assign MISO     = r_miso;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_word_done    <= 1'b0;
      r_rd_addr_done <= 1'b0;
      r_tx_busy      <= 1'b0;
      r_tx_done      <= 1'b0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_miso         <= 1'b0;
      r_rx_valid     <= 1'b0;
      r_rx_data      <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_abort) begin
        // Abort drops any partial word; rd_addr_done deliberately survives.
        r_state     <= S_IDLE;
        r_bit_cnt   <= '0;
        r_word_done <= 1'b0;
        r_tx_busy   <= 1'b0;
        r_tx_done   <= 1'b0;
        r_miso      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!SS_n) r_state <= S_CHK_CMD;
          end
          S_CHK_CMD: begin
            r_shift     <= {{(WORD_W-2){1'b0}}, MOSI};
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            r_tx_busy   <= 1'b0;
            r_tx_done   <= 1'b0;
            if (!MOSI)               r_state <= S_WRITE;
            else if (r_rd_addr_done) r_state <= S_READ_DATA;
            else                     r_state <= S_READ_ADD;
          end
          S_WRITE, S_READ_ADD, S_READ_DATA: begin
            if (!r_word_done) begin
              r_shift   <= {r_shift[WORD_W-3:0], MOSI};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                r_rx_data   <= {r_shift, MOSI};
                r_rx_valid  <= 1'b1;
                r_word_done <= 1'b1;
                if (r_state == S_READ_ADD) r_rd_addr_done <= 1'b1;
              end
            end else if (r_state == S_READ_DATA && !r_tx_done) begin
              if (!r_tx_busy) begin
                if (tx_valid) begin
                  r_miso     <= tx_data[TX_W-1];
                  r_tx_shift <= {tx_data[TX_W-2:0], 1'b0};
                  r_tx_cnt   <= TX_LAST;
                  r_tx_busy  <= 1'b1;
                end
              end else if (r_tx_cnt != '0) begin
                r_miso     <= r_tx_shift[TX_W-1];
                r_tx_shift <= {r_tx_shift[TX_W-2:0], 1'b0};
                r_tx_cnt   <= r_tx_cnt - 1'b1;
                if (r_tx_cnt == TC_W'(1)) r_rd_addr_done <= 1'b0;
              end else begin
                r_miso    <= 1'b0;
                r_tx_busy <= 1'b0;
                r_tx_done <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Bench for spi_slave_fsm: frame-level model of words, read-address tracking
// and MISO byte serialisation, driven by directed and randomized frames.
module tb_spi_slave_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state: last delivered word and the pending read address flag.
  logic [9:0] last_word = 10'h000;
  bit         model_rd_done = 1'b0;

  spi_slave_fsm dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SPI frame: select edge, 10 bit edges, optional tx phase, deselect.
  // abort_bit >= 0 raises SS_n on that bit edge; tx_stop >= 0 aborts (or
  // resets when tx_rst) on that edge of the tx phase.
  task automatic run_frame(input logic [9:0] w, input int abort_bit, input int tx_delay,
                           input logic [7:0] txb, input int tx_stop, input bit tx_rst);
    bit   is_rd_data;
    bit   is_rd_add;
    logic exp_miso;
    SS_n = 1'b0; MOSI = 1'($urandom); tx_valid = 1'b0; tx_data = 8'($urandom);
    tick();
    checks++;
    if (MISO !== 1'b0 || rx_valid !== 1'b0)
      $display("FAIL select_edge: MISO=%b rx_valid=%b required 0 0", MISO, rx_valid);
    if (MISO !== 1'b0 || rx_valid !== 1'b0) errors++;
    for (int i = 0; i < 10; i++) begin
      MOSI = w[9-i];
      if (i == abort_bit) begin
        SS_n = 1'b1;
        tick();
        checks++;
        if (rx_valid !== 1'b0 || MISO !== 1'b0 || rx_data !== last_word) begin
          errors++;
          $display("FAIL abort_bit: rx_valid=%b MISO=%b rx_data=%03h required 0 0 %03h",
                   rx_valid, MISO, rx_data, last_word);
        end
        $display("frame %03h aborted at bit %0d", w, i);
        return;
      end
      tick();
      checks++;
      if (rx_valid !== (i == 9)) begin
        errors++;
        $display("FAIL rx_valid_bit%0d: got %b required %b", i, rx_valid, (i == 9));
      end
      checks++;
      if (MISO !== 1'b0) begin
        errors++;
        $display("FAIL miso_during_rx bit%0d: got %b required 0", i, MISO);
      end
    end
    checks++;
    if (rx_data !== w) begin
      errors++;
      $display("FAIL rx_data: got %03h required %03h", rx_data, w);
    end
    last_word  = w;
    is_rd_data = w[9] && model_rd_done;
    is_rd_add  = w[9] && !model_rd_done;
    if (is_rd_add) model_rd_done = 1'b1;
    for (int d = 0; d < tx_delay; d++) begin
      tx_valid = 1'b0; tx_data = 8'($urandom);
      tick();
      checks++;
      if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== last_word) begin
        errors++;
        $display("FAIL tx_wait%0d: MISO=%b rx_valid=%b rx_data=%03h required 0 0 %03h",
                 d, MISO, rx_valid, rx_data, last_word);
      end
    end
    tx_valid = 1'b1; tx_data = txb;
    for (int k = 0; k < 10; k++) begin
      if (k == tx_stop) begin
        if (tx_rst) begin
          rst = 1'b1; SS_n = 1'b1;
          tick();
          checks++;
          if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
            errors++;
            $display("FAIL mid_reset: MISO=%b rx_valid=%b rx_data=%03h required 0 0 000",
                     MISO, rx_valid, rx_data);
          end
          rst = 1'b0; model_rd_done = 1'b0; last_word = 10'h000;
        end else begin
          SS_n = 1'b1;
          tick();
          checks++;
          if (MISO !== 1'b0) begin
            errors++;
            $display("FAIL tx_abort: MISO=%b required 0", MISO);
          end
        end
        tx_valid = 1'b0;
        $display("frame %03h tx phase %s at edge %0d", w, tx_rst ? "reset" : "aborted", k);
        return;
      end
      tick();
      exp_miso = (is_rd_data && k < 8) ? txb[7-k] : 1'b0;
      checks++;
      if (MISO !== exp_miso || rx_valid !== 1'b0) begin
        errors++;
        $display("FAIL miso_tx%0d: MISO=%b rx_valid=%b required %b 0", k, MISO, rx_valid, exp_miso);
      end
    end
    if (is_rd_data) model_rd_done = 1'b0;
    tx_valid = 1'b0; SS_n = 1'b1;
    tick();
    checks++;
    if (MISO !== 1'b0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL deselect: MISO=%b rx_valid=%b required 0 0", MISO, rx_valid);
    end
    $display("frame %03h %s delay %0d tx %02h", w,
             is_rd_data ? "READ_DATA" : (is_rd_add ? "READ_ADD" : "WRITE"), tx_delay, txb);
  endtask

  task automatic test_reset();
    rst = 1'b1; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    checks++;
    if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
      errors++;
      $display("FAIL reset: MISO=%b rx_valid=%b rx_data=%03h required 0 0 000", MISO, rx_valid, rx_data);
    end
    rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0;
    tick();
    checks++;
    if (MISO !== 1'b0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: MISO=%b rx_valid=%b required 0 0", MISO, rx_valid);
    end
    $display("reset applied");
  endtask

  task automatic test_write();
    run_frame(10'h0A5, -1, 0, 8'hA5, -1, 1'b0);
    run_frame(10'h13C, -1, 0, 8'h5A, -1, 1'b0);
  endtask

  task automatic test_read();
    run_frame(10'h2A5, -1, 0, 8'h3C, -1, 1'b0);
    run_frame(10'h300, -1, 0, 8'h3C, -1, 1'b0);
    run_frame(10'h2C3, -1, 1, 8'hFF, -1, 1'b0);
    run_frame(10'h3FF, -1, 0, 8'h81, -1, 1'b0);
  endtask

  task automatic test_abort();
    run_frame({2'b01, 8'($urandom)}, 5, 0, 8'h00, -1, 1'b0);
    run_frame(10'h0F0, -1, 0, 8'h00, -1, 1'b0);
    run_frame(10'h155, 9, 0, 8'h00, -1, 1'b0);
    run_frame(10'h2AA, 0, 0, 8'h00, -1, 1'b0);
    run_frame(10'h211, -1, 0, 8'h00, -1, 1'b0);
    run_frame(10'h300, -1, 0, 8'hC3, 3, 1'b0);
    run_frame(10'h300, -1, 0, 8'hC3, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    if (!model_rd_done) run_frame(10'h2A5, -1, 0, 8'h00, -1, 1'b0);
    run_frame(10'h300, -1, 0, 8'h5A, 4, 1'b1);
    run_frame(10'h2C3, -1, 0, 8'hFF, -1, 1'b0);
    run_frame(10'h300, -1, 0, 8'h96, -1, 1'b0);
  endtask

  task automatic test_tx_delay();
    if (!model_rd_done) run_frame(10'h2A5, -1, 0, 8'h00, -1, 1'b0);
    run_frame(10'h300, -1, 3, 8'h3C, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int ab;
      int ts;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
      ts = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_frame(10'($urandom), ab, int'($urandom_range(0, 3)), 8'($urandom), ts,
                1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    rst = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_reset_mid();
    test_tx_delay();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
